// File: rtl/sig_an_pkg.sv
// Shared types and constants for the single-input signature analyzer.
// State encoding and default feedback/seed values used by the FSM and the SISR.
package sig_an_pkg;

    localparam int WIDTH = 8;

    // x^8 + x^4 + x^3 + x^2 + 1, with the x^8 term implicit
    localparam logic [WIDTH-1:0] DEFAULT_POLY = 8'h1D;
    localparam logic [WIDTH-1:0] DEFAULT_SEED = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sig_an_sisr.sv
// Single-input signature register: loads SEED, or shifts one din bit through POLY feedback.
// Latency: one cycle per absorbed bit; sig_shift shows the would-be next value combinationally.
// Backpressure: none; the register holds whenever neither load nor shift_en is asserted.
module sig_an_sisr
    import sig_an_pkg::*;
#(
    parameter int               WIDTH = sig_an_pkg::WIDTH,
    parameter logic [WIDTH-1:0] POLY  = DEFAULT_POLY,
    parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] sig_shift
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic             fb;

    always_comb begin
        fb        = sig_q[WIDTH-1] ^ din;
        sig_shift = {sig_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{fb}} & POLY);
        sig_d     = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (shift_en) begin
            sig_d = sig_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/sig_analyzer_8.sv
// Signature analyzer: compacts n_bits qualified serial bits and compares against a golden value.
// Latency: done/pass registered, high the cycle after the last absorbed bit (next cycle if n_bits=0).
// Backpressure: din_valid low stalls compaction; optional abort port under SIGAN_ABORT_EN.
module sig_analyzer_8
    import sig_an_pkg::*;
#(
    parameter int               WIDTH = sig_an_pkg::WIDTH,
    parameter logic [WIDTH-1:0] POLY  = DEFAULT_POLY,
    parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             din,
    input  logic             din_valid,
    input  logic [7:0]       n_bits,
    input  logic [WIDTH-1:0] golden,
`ifdef SIGAN_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    state_t           state_q, state_d;
    logic [7:0]       count_q, count_d;
    logic [7:0]       n_bits_q, n_bits_d;
    logic [WIDTH-1:0] golden_q, golden_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             sisr_load;
    logic             sisr_shift;
    logic [WIDTH-1:0] sig_shift;
    logic             abort_req;

`ifdef SIGAN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        n_bits_d   = n_bits_q;
        golden_d   = golden_q;
        pass_d     = pass_q;
        sisr_load  = 1'b0;
        sisr_shift = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sisr_load = 1'b1;
                    count_d   = 8'd0;
                    n_bits_d  = n_bits;
                    golden_d  = golden;
                    if (n_bits == 8'd0) begin
                        state_d = ST_DONE;
                        pass_d  = (SEED == golden);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // abort wins over a coincident valid bit so the signature is left untouched
                if (abort_req) begin
                    state_d = ST_IDLE;
                end else if (din_valid) begin
                    sisr_shift = 1'b1;
                    count_d    = count_q + 8'd1;
                    if (count_q == n_bits_q - 8'd1) begin
                        state_d = ST_DONE;
                        pass_d  = (sig_shift == golden_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != ST_DONE) begin
            pass_d = 1'b0;
        end
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            count_q  <= 8'd0;
            n_bits_q <= 8'd0;
            golden_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            n_bits_q <= n_bits_d;
            golden_q <= golden_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    sig_an_sisr #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_sisr (
        .clk       (CLK),
        .rst       (RST),
        .load      (sisr_load),
        .shift_en  (sisr_shift),
        .din       (din),
        .sig       (signature),
        .sig_shift (sig_shift)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;

endmodule

// File: tb/tb_sig_analyzer_8.sv
// Randomized bench for sig_analyzer_8 against a per-bit polynomial reference model.
module tb_sig_analyzer_8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start;
    logic       din;
    logic       din_valid;
    logic [7:0] n_bits;
    logic [7:0] golden;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] signature;
`ifdef SIGAN_ABORT_EN
    logic       abort;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    sig_analyzer_8 dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .n_bits    (n_bits),
        .golden    (golden),
`ifdef SIGAN_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Multiply by x modulo x^8+x^4+x^3+x^2+1, adding the input bit at the top.
    function automatic logic [7:0] ref_step(input logic [7:0] s, input logic b);
        int v;
        v = int'(s) * 2;
        if ((((int'(s) >> 7) & 1) ^ int'(b)) != 0) v = v ^ 'h11D;
        return 8'(v % 256);
    endfunction

    // din_mode: 0 random, 1 ones, 2 zeros. vld_mode: 0 always, 1 toggle, 2 random.
    // gold_mode: 0 matching, 1 expected^1, 2 random mismatch.
    task automatic run_stream(input int nb, input int din_mode, input int vld_mode,
                              input int gold_mode, input bit noisy, output int fin_cycles);
        logic [255:0] bits;
        logic [7:0]   msig;
        logic [7:0]   expect_sig;
        logic [7:0]   gold;
        logic         v;
        int           absorbed;
        int           cycles;

        bits = '0;
        for (int i = 0; i < nb; i++) begin
            bits[i] = (din_mode == 1) ? 1'b1 : (din_mode == 2) ? 1'b0 : 1'($urandom);
        end
        expect_sig = 8'h00;
        for (int i = 0; i < nb; i++) expect_sig = ref_step(expect_sig, bits[i]);
        case (gold_mode)
            0:       gold = expect_sig;
            1:       gold = expect_sig ^ 8'h01;
            default: gold = expect_sig ^ 8'($urandom_range(1, 255));
        endcase

        start = 1'b1; n_bits = 8'(nb); golden = gold; din_valid = 1'b0; din = 1'($urandom);
        tick();
        start = 1'b0; n_bits = 8'($urandom); golden = 8'($urandom);
        fin_cycles = 1;
        msig = 8'h00;
        absorbed = 0;
        cycles = 0;

        check_eq("start_busy", busy, nb != 0);
        check_eq("start_done", done, nb == 0);
        check_eq("start_sig", signature, 8'h00);
        check_eq("start_pass", pass, (nb == 0) && (gold == 8'h00));

        while (absorbed < nb && cycles < 4000) begin
            case (vld_mode)
                0:       v = 1'b1;
                1:       v = (cycles % 2) == 0;
                default: v = ($urandom_range(0, 99) < 60);
            endcase
            din_valid = v;
            din = v ? bits[absorbed] : 1'($urandom);
            if (noisy) begin
                start = 1'($urandom);
                n_bits = 8'($urandom);
                golden = 8'($urandom);
            end
            tick();
            cycles++;
            if (v) begin
                msig = ref_step(msig, bits[absorbed]);
                absorbed++;
            end
            check_eq("run_sig", signature, msig);
            check_eq("run_busy", busy, absorbed < nb);
            check_eq("run_done", done, absorbed >= nb);
            check_eq("run_pass", pass, (absorbed >= nb) && (msig == gold));
        end
        check_eq("run_timeout", absorbed, nb);
        start = 1'b0;
        din_valid = 1'b0;
        fin_cycles = cycles + 1;

        for (int k = 0; k < 2; k++) begin
            din_valid = 1'($urandom);
            din = 1'($urandom);
            tick();
            check_eq("hold_sig", signature, expect_sig);
            check_eq("hold_done", done, 1'b1);
            check_eq("hold_busy", busy, 1'b0);
            check_eq("hold_pass", pass, expect_sig == gold);
        end
        din_valid = 1'b0;
    endtask

    initial begin
        int         cyc;
        logic [7:0] msig;

        RST = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0;
        n_bits = 8'd0; golden = 8'd0;
`ifdef SIGAN_ABORT_EN
        abort = 1'b0;
`endif
        tick();
        tick();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_pass", pass, 1'b0);
        check_eq("rst_sig", signature, 8'h00);
        RST = 1'b0;

        run_stream(1, 1, 0, 0, 1'b0, cyc);
        check_eq("one_bit_sig", signature, 8'h1D);
        check_eq("one_bit_pass", pass, 1'b1);

        run_stream(2, 1, 0, 0, 1'b0, cyc);
        check_eq("two_bit_sig", signature, 8'h27);
        check_eq("two_bit_pass", pass, 1'b1);
        run_stream(2, 1, 0, 1, 1'b0, cyc);
        check_eq("two_bit_bad_sig", signature, 8'h27);
        check_eq("two_bit_bad_pass", pass, 1'b0);

        run_stream(8, 2, 1, 2, 1'b0, cyc);
        check_eq("toggle_cycles", cyc, 16);
        check_eq("toggle_sig", signature, 8'h00);

        run_stream(0, 0, 0, 0, 1'b0, cyc);
        check_eq("zero_len_pass", pass, 1'b1);
        run_stream(4, 0, 2, 0, 1'b1, cyc);

        // reset in the middle of a run, with competing start and valid
        start = 1'b1; n_bits = 8'd8; golden = 8'h00;
        tick();
        start = 1'b0;
        msig = 8'h00;
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'b1; din = 1'b1;
            tick();
            msig = ref_step(msig, 1'b1);
        end
        check_eq("pre_rst_sig", signature, msig);
        RST = 1'b1; start = 1'b1; din_valid = 1'b1;
        tick();
        RST = 1'b0; start = 1'b0; din_valid = 1'b0;
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_done", done, 1'b0);
        check_eq("mid_rst_pass", pass, 1'b0);
        check_eq("mid_rst_sig", signature, 8'h00);
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        check_eq("post_rst_idle", busy, 1'b0);
        check_eq("post_rst_sig", signature, 8'h00);
        run_stream(8, 1, 0, 0, 1'b0, cyc);

`ifdef SIGAN_ABORT_EN
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_in_done", done, 1'b1);
        start = 1'b1; n_bits = 8'd8; golden = 8'h00;
        tick();
        start = 1'b0;
        msig = 8'h00;
        for (int i = 0; i < 2; i++) begin
            din_valid = 1'b1; din = 1'($urandom);
            msig = ref_step(msig, din);
            tick();
        end
        abort = 1'b1; din_valid = 1'b1; din = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("abort_busy", busy, 1'b0);
            check_eq("abort_done", done, 1'b0);
            check_eq("abort_sig", signature, msig);
            din_valid = 1'($urandom);
            tick();
        end
        din_valid = 1'b0;
`endif

        for (int r = 0; r < 25; r++) begin
            run_stream((r % 8 == 7) ? 0 : int'($urandom_range(1, 30)), 0, 2,
                       int'($urandom_range(0, 2)), 1'($urandom), cyc);
        end
        run_stream(255, 0, 2, 0, 1'b0, cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sig_analyzer_8.md
SIG_ANALYZER_8 -- requirements
Module: sig_analyzer_8

Interface
REQ-001 Parameter: WIDTH, 8, signature register width in bits.
REQ-002 Parameter: POLY, 8'h1D, feedback taps for x^8+x^4+x^3+x^2+1; bit0 SHALL be 1.
REQ-003 Parameter: SEED, 8'h00, signature value loaded on start.
REQ-004 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begins a compaction run; sampled only in IDLE or DONE.
REQ-007 din  input  1  serial response bit from the circuit under test (for example, an LFSR-driven CUT output).
REQ-008 din_valid  input  1  qualifies din; bits are absorbed only when this input is high.
REQ-009 n_bits  input  8  number of valid bits to compact; latched on start.
REQ-010 golden  input  8  expected signature; latched on start.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  high while in DONE.
REQ-013 pass  output  1  in DONE, high when signature equals latched golden; low otherwise.
REQ-014 signature  output  8  current signature register contents.

Function
REQ-015 FSM states: IDLE, RUN, DONE. Encoding SHALL be a shared enum.
REQ-016 IDLE/DONE with start=1 and latched n_bits≠0: signature←SEED, count←0, latch n_bits/golden, next state RUN.
REQ-017 IDLE/DONE with start=1 and n_bits=0: signature←SEED, next state DONE directly; pass=(SEED==golden).
REQ-018 RUN with din_valid=1: fb = signature[7]^din; signature ← {signature[6:0],0} ^ ({8{fb}} & POLY); count ← count+1.
REQ-019 RUN with din_valid=0: signature and count SHALL hold.
REQ-020 RUN, absorbing bit number n_bits (count==n_bits-1 with din_valid=1): next state DONE; done high the cycle after the last bit.
REQ-021 count SHALL be 8 bits; n_bits=255 SHALL absorb exactly 255 bits with no wrap.
REQ-022 start while in RUN SHALL be ignored.
REQ-023 DONE SHALL hold signature, pass, and done until start or RST; start in DONE SHALL restart per REQ-016/017 in the same cycle.
REQ-024 pass SHALL be 0 outside DONE.

Reset
REQ-025 RST=1 at a clock edge: state←IDLE, signature←SEED, count←0, busy/done/pass←0, latched golden/n_bits←0.
REQ-026 RST SHALL take priority over start, din_valid, and abort in every state, including mid-RUN.

Configuration
REQ-027 Macro SIGAN_ABORT_EN: when defined, add input port abort (1 bit); abort=1 in RUN SHALL return to IDLE next cycle with signature held and done not asserted; abort outside RUN SHALL be ignored.
REQ-028 Without SIGAN_ABORT_EN, the abort port SHALL NOT exist and RUN exits only via REQ-020 or RST.

Structure
REQ-029 Package sig_an_pkg SHALL hold the state enum, the default POLY and SEED constants, and WIDTH.
REQ-030 Sub-module sig_an_sisr SHALL implement the single-input signature register (load, shift-enable, din, POLY); the FSM and counter SHALL reside in sig_analyzer_8.

Verification
REQ-031 Reset, then start with n_bits=1, golden=8'h1D, din=1 valid for one cycle -> signature=8'h1D, done=1, pass=1 on the next cycle.
REQ-032 start with n_bits=2, din=1,1 -> signature 8'h1D then 8'h27; golden=8'h27 gives pass=1, golden=8'h26 gives pass=0.
REQ-033 start with n_bits=8, all din=0, din_valid toggled 1/0 each cycle -> completes after 16 cycles, signature=8'h00; busy high throughout.
REQ-034 start with n_bits=0, golden=8'h00 -> DONE on the next cycle, pass=1; a start pulse during a RUN with n_bits=4 is ignored.
REQ-035 RST asserted mid-RUN after 3 of 8 bits -> IDLE next cycle, signature=8'h00, busy/done/pass=0; a following run gives results identical to a fresh run.
REQ-036 With SIGAN_ABORT_EN defined, abort after 2 of 8 bits -> IDLE, done never asserted, signature holds its 2-bit value.
